bitfn_sched: RTL and testbench

Round-robin scheduler that shares one pipelined bit-function unit (bit reverse, popcount, count-leading-zeros, byte swap) among NREQ requesters. It sits between the integer-side clients (decode helpers, test harnesses) and the bit-manipulation datapath. It arbitrates requests, sequences operands through a 2-stage pipeline with full backpressure, and returns each result tagged with the originating requester ID.

---
 rtl/bitfn_sched.sv | 150 +++++++++++++++
 tb/tb_bitfn_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitfn_sched.sv
// bitfn_sched: round-robin arbiter in front of a two-stage bit-function pipeline
// (reverse, popcount, count-leading-zeros, byte swap). Each result carries the
// index of the requester that issued it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// A requester may drop req_valid at any time without penalty. req_ready never
// depends on req_op/req_data. rsp_id/rsp_data hold steady while rsp_valid=1 and
// rsp_ready=0.
module bitfn_sched #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int NBYTES = WIDTH / 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

  stage_t           s1_state, s1_next;
  stage_t           s2_state, s2_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic [NREQ-1:0]  grant;
  logic             found;
  int               idx;
  logic             s1_free, s2_free, xfer, accept;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_data;
  logic [IDW-1:0]   s1_id;
  logic [WIDTH-1:0] s2_data;
  logic [IDW-1:0]   s2_id;
  logic [WIDTH-1:0] fn_result;

  // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = IDW'(idx);
      end
    end
  end

  // Pipe occupancy next-state: S2 drains on rsp_ready, S1 advances whenever S2 frees up.
  always_comb begin
    s2_free = (s2_state == EMPTY) || rsp_ready;
    s1_free = (s1_state == EMPTY) || s2_free;
    xfer    = (s1_state == FULL) && s2_free;
    accept  = found && s1_free && rst_n;
    s1_next = s1_state;
    s2_next = s2_state;
    if (accept)         s1_next = FULL;
    else if (xfer)      s1_next = EMPTY;
    if (xfer)           s2_next = FULL;
    else if (rsp_ready) s2_next = EMPTY;
  end

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign req_ready = accept ? grant : '0;

  // Bit function of the operand held in S1.
  always_comb begin
    fn_result = '0;
    case (s1_op)
      2'b00: begin
        for (int k = 0; k < WIDTH; k++) fn_result[k] = s1_data[WIDTH-1-k];
      end
      2'b01: begin
        for (int k = 0; k < WIDTH; k++) fn_result = fn_result + WIDTH'(s1_data[k]);
      end
      2'b10: begin
        // Highest set bit wins; an all-zero operand keeps the value WIDTH.
        fn_result = WIDTH'(WIDTH);
        for (int k = 0; k < WIDTH; k++) begin
          if (s1_data[k]) fn_result = WIDTH'(WIDTH - 1 - k);
        end
      end
      default: begin
        for (int j = 0; j < NBYTES; j++) fn_result[8*j +: 8] = s1_data[8*(NBYTES-1-j) +: 8];
      end
    endcase
  end

  // Stage occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_state <= EMPTY;
      s2_state <= EMPTY;
    end else begin
      s1_state <= s1_next;
      s2_state <= s2_next;
    end
  end

  // Round-robin pointer moves past the accepted requester, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // S1 captures op, operand and id of the accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_op   <= '0;
      s1_data <= '0;
      s1_id   <= '0;
    end else if (accept) begin
      s1_op   <= req_op[2*gnt_id +: 2];
      s1_data <= req_data[WIDTH*gnt_id +: WIDTH];
      s1_id   <= gnt_id;
    end
  end

  // S2 captures the computed result; it only changes on a transfer, so it holds under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_data <= '0;
      s2_id   <= '0;
    end else if (xfer) begin
      s2_data <= fn_result;
      s2_id   <= s1_id;
    end
  end

  assign rsp_valid = (s2_state == FULL);
  assign rsp_id    = s2_id;
  assign rsp_data  = s2_data;

endmodule

// File: tb/tb_bitfn_sched.sv
// Bench for bitfn_sched: directed cases plus a scoreboard fed at each accept and
// drained at each response.
module tb_bitfn_sched;

  localparam int W   = 64;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;

  // Narrow instance for the 16-bit reverse case.
  logic [1:0]  v16, r16;
  logic [3:0]  op16;
  logic [31:0] d16;
  logic        rv16;
  logic [0:0]  rid16;
  logic [15:0] rd16;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;

  logic [IDW+W-1:0] exp_q[$];
  logic [IDW-1:0]   id_log[$];
  logic [W-1:0]     data_log[$];
  int               cyc_log[$];

  logic           stall_prev = 1'b0;
  logic [IDW-1:0] prev_id;
  logic [W-1:0]   prev_data;

  bitfn_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  bitfn_sched #(.WIDTH(16), .NREQ(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(v16), .req_ready(r16),
    .req_op(op16), .req_data(d16), .rsp_valid(rv16),
    .rsp_ready(1'b1), .rsp_id(rid16), .rsp_data(rd16)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference bit functions, written independently of the RTL loops.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d);
    logic [W-1:0] r;
    int n;
    case (op)
      2'b00: r = {<<{d}};
      2'b01: r = W'($countones(d));
      2'b10: begin
        n = 0;
        while (n < W && !d[W-1-n]) n++;
        r = W'(n);
      end
      default: r = {<<8{d}};
    endcase
    return r;
  endfunction

  // Monitor: sampled on the falling edge, it sees the handshakes that complete at the next rise.
  always @(negedge clk) begin
    logic [IDW+W-1:0] e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (stall_prev && rsp_valid) begin
        chk("hold_id", 64'(rsp_id), 64'(prev_id));
        chk("hold_data", rsp_data, prev_data);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 64'(rsp_id), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e[IDW+W-1:W]));
          chk("rsp_data", rsp_data, e[W-1:0]);
        end
        id_log.push_back(rsp_id);
        data_log.push_back(rsp_data);
        cyc_log.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_cnt++;
          exp_q.push_back({IDW'(i), model(req_op[2*i +: 2], req_data[W*i +: W])});
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      prev_id    = rsp_id;
      prev_data  = rsp_data;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_all();
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = 2'($urandom_range(0, 3));
      req_data[W*i +: W] = {$urandom, $urandom};
    end
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] d);
    bit got;
    got = 1'b0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_op[2*id +: 2] = op;
    req_data[W*id +: W] = d;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    step();
    req_valid = '0;
    chk("issue_accept", 64'(got), 64'd1);
  endtask

  task automatic present_check(input string tag, input logic [N-1:0] mask, input logic [N-1:0] exp);
    randomize_all();
    req_valid = mask;
    @(negedge clk);
    chk(tag, 64'(req_ready), 64'(exp));
    step();
    req_valid = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 60) begin
      step();
      n++;
    end
    chk("drain_q", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    req_valid = '1;
    req_op = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    v16 = '0;
    op16 = '0;
    d16 = '0;

    // Reset state
    repeat (3) step();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    req_valid = '0;

    // Reverse latency: presented before edge A, visible after edge A+1
    req_valid = 4'b0001;
    req_op[1:0] = 2'b00;
    req_data[W-1:0] = 64'h1;
    v16 = 2'b01;
    op16 = 4'b0000;
    d16 = 32'h0000_A442;
    step();
    chk("rev_early_valid", 64'(rsp_valid), 64'd0);
    req_valid = '0;
    v16 = '0;
    step();
    chk("rev_valid", 64'(rsp_valid), 64'd1);
    chk("rev_data", rsp_data, 64'h8000_0000_0000_0000);
    chk("rev_id", 64'(rsp_id), 64'd0);
    chk("rev16_valid", 64'(rv16), 64'd1);
    chk("rev16_data", 64'(rd16), 64'h4225);
    wait_drain();

    // Function corner values, then random operands
    data_log.delete();
    issue(0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1, 2'b10, 64'h0);
    issue(2, 2'b10, 64'h1);
    issue(3, 2'b11, 64'h0102_0304_0506_0708);
    wait_drain();
    chk("fn_count", 64'(data_log.size()), 64'd4);
    if (data_log.size() == 4) begin
      chk("popcount_ones", data_log[0], 64'd64);
      chk("clz_zero", data_log[1], 64'd64);
      chk("clz_one", data_log[2], 64'd63);
      chk("bswap", data_log[3], 64'h0807_0605_0403_0201);
    end
    for (int k = 0; k < 12; k++) begin
      issue($urandom_range(0, N-1), 2'($urandom_range(0, 3)), {$urandom, $urandom});
    end
    wait_drain();

    // Backpressure: 6 stalled cycles admit exactly two requests
    base = id_log.size();
    rsp_ready = 1'b0;
    acc_cnt = 0;
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      randomize_all();
      step();
    end
    chk("bp_accepts", 64'(acc_cnt), 64'd2);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_drain();
    chk("bp_rsp_count", 64'(id_log.size() - base), 64'd2);

    // Pointer: req 2 then req 1 alone, then the search must wrap around
    issue(2, 2'b00, {$urandom, $urandom});
    issue(1, 2'b01, {$urandom, $urandom});
    present_check("grant_from_ptr2", 4'b1010, 4'b1000);
    present_check("grant_wrap_ptr0", 4'b0110, 4'b0010);
    present_check("grant_ptr2_again", 4'b0101, 4'b0100);
    wait_drain();

    // Reset with two requests in flight
    rsp_ready = 1'b0;
    req_valid = '1;
    randomize_all();
    step();
    step();
    chk("mid_inflight", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b1;
    id_log.delete();
    cyc_log.delete();

    // Fairness: all valid continuously, first grant is req 0
    for (int k = 0; k < 16; k++) begin
      randomize_all();
      step();
    end
    req_valid = '0;
    wait_drain();
    chk("fair_count", 64'(id_log.size()), 64'd16);
    for (int k = 0; k < id_log.size() && k < 16; k++) begin
      chk("fair_id", 64'(id_log[k]), 64'(k % 4));
      if (k > 0) chk("fair_gap", 64'(cyc_log[k] - cyc_log[k-1]), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
